// File: rtl/ahblite_timer.sv
// AHB-Lite zero-wait-state slave: 32-bit down-counting timer with programmable prescaler
// and level interrupt output.
module ahblite_timer #(
   parameter int unsigned PRESC_W = 16
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   output logic        TIMER_IRQ
);

   localparam logic [2:0] IdxCtrl   = 3'd0;
   localparam logic [2:0] IdxLoad   = 3'd1;
   localparam logic [2:0] IdxValue  = 3'd2;
   localparam logic [2:0] IdxStatus = 3'd3;
   localparam logic [2:0] IdxPresc  = 3'd4;

   logic               dp_valid_q, dp_write_q, dp_word_q;
   logic [2:0]         dp_idx_q;

   // ctrl bits: {reload, irqen, en}
   logic [2:0]         ctrl_q, ctrl_d;
   logic [31:0]        load_q, load_d;
   logic [31:0]        value_q, value_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
   logic               irq_q, irq_d;

   logic accept, wr_en, wr_ctrl, wr_load, wr_status, wr_presc;
   logic tick, expire;
   logic unused_bits;

   assign unused_bits = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

   assign accept    = HSEL & HREADY & HTRANS[1];
   assign wr_en     = dp_valid_q & dp_write_q & dp_word_q;
   assign wr_ctrl   = wr_en & (dp_idx_q == IdxCtrl);
   assign wr_load   = wr_en & (dp_idx_q == IdxLoad);
   assign wr_status = wr_en & (dp_idx_q == IdxStatus);
   assign wr_presc  = wr_en & (dp_idx_q == IdxPresc);

   // A coincident LOAD write swallows the tick entirely.
   assign tick   = ctrl_q[0] & (presc_cnt_q == presc_q) & ~wr_load;
   assign expire = tick & (value_q == 32'd0);

   always_comb begin
      ctrl_d      = ctrl_q;
      load_d      = load_q;
      value_d     = value_q;
      presc_d     = presc_q;
      presc_cnt_d = presc_cnt_q;
      irq_d       = irq_q;

      if (wr_ctrl) begin
         ctrl_d = HWDATA[2:0];
      end else if (expire && !ctrl_q[2]) begin
         ctrl_d[0] = 1'b0;
      end

      if (wr_load) begin
         load_d = HWDATA;
      end
      if (wr_presc) begin
         presc_d = HWDATA[PRESC_W-1:0];
      end

      if (wr_load) begin
         value_d     = HWDATA;
         presc_cnt_d = '0;
      end else if (ctrl_q[0]) begin
         if (tick) begin
            presc_cnt_d = '0;
            if (value_q != 32'd0) begin
               value_d = value_q - 32'd1;
            end else if (ctrl_q[2]) begin
               value_d = load_q;
            end
         end else begin
            presc_cnt_d = presc_cnt_q + 1'b1;
         end
      end

      // Set beats a same-cycle write-one-to-clear.
      if (expire) begin
         irq_d = 1'b1;
      end else if (wr_status && HWDATA[0]) begin
         irq_d = 1'b0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         dp_valid_q  <= 1'b0;
         dp_write_q  <= 1'b0;
         dp_word_q   <= 1'b0;
         dp_idx_q    <= '0;
         ctrl_q      <= '0;
         load_q      <= '0;
         value_q     <= '0;
         presc_q     <= '0;
         presc_cnt_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         dp_valid_q <= accept;
         if (accept) begin
            dp_idx_q   <= HADDR[4:2];
            dp_write_q <= HWRITE;
            dp_word_q  <= (HSIZE == 3'b010);
         end
         ctrl_q      <= ctrl_d;
         load_q      <= load_d;
         value_q     <= value_d;
         presc_q     <= presc_d;
         presc_cnt_q <= presc_cnt_d;
         irq_q       <= irq_d;
      end
   end

   always_comb begin
      HRDATA = '0;
      if (dp_valid_q && !dp_write_q) begin
         case (dp_idx_q)
            IdxCtrl:   HRDATA = {29'd0, ctrl_q};
            IdxLoad:   HRDATA = load_q;
            IdxValue:  HRDATA = value_q;
            IdxStatus: HRDATA = {31'd0, irq_q};
            IdxPresc:  HRDATA = 32'(presc_q);
            default:   HRDATA = '0;
         endcase
      end
   end

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;
   assign TIMER_IRQ = irq_q & ctrl_q[1];

endmodule

// File: tb/tb_ahblite_timer.sv
// Self-checking bench for ahblite_timer: directed scenarios plus randomized count checks
// against closed-form tick arithmetic.
module tb_ahblite_timer;

   localparam logic [31:0] ACTRL   = 32'h00;
   localparam logic [31:0] ALOAD   = 32'h04;
   localparam logic [31:0] AVALUE  = 32'h08;
   localparam logic [31:0] ASTATUS = 32'h0C;
   localparam logic [31:0] APRESC  = 32'h10;
   localparam logic [2:0]  SZW     = 3'b010;

   logic        HCLK    = 1'b0;
   logic        HRESETn = 1'b0;
   logic        HSEL    = 1'b0;
   logic [31:0] HADDR   = '0;
   logic [1:0]  HTRANS  = '0;
   logic [2:0]  HSIZE   = 3'b010;
   logic        HWRITE  = 1'b0;
   logic [31:0] HWDATA  = '0;
   logic        HREADY  = 1'b1;
   logic        HREADYOUT, HRESP, TIMER_IRQ;
   logic [31:0] HRDATA;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   ahblite_timer #(.PRESC_W(16)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HSIZE     (HSIZE),
      .HWRITE    (HWRITE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .TIMER_IRQ (TIMER_IRQ)
   );

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   // One bus cycle: wd is data for the data phase now in flight; a is the new address phase.
   task automatic drive(input logic sel, input logic wr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd);
      HSEL   = sel;
      HTRANS = sel ? 2'b10 : 2'b00;
      HWRITE = wr;
      HADDR  = a;
      HSIZE  = sz;
      HWDATA = wd;
      @(posedge HCLK);
      #1;
   endtask

   task automatic wr_sz(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
      drive(1'b1, 1'b1, a, sz, 32'd0);
      drive(1'b0, 1'b0, 32'd0, SZW, d);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wr_sz(a, d, SZW);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d, output int at,
                     output logic irq);
      drive(1'b1, 1'b0, a, SZW, 32'd0);
      d   = HRDATA;
      at  = cyc;
      irq = TIMER_IRQ;
      drive(1'b0, 1'b0, 32'd0, SZW, 32'd0);
   endtask

   task automatic test_reset();
      logic [31:0] d;
      int at;
      logic irq;
      wr(ALOAD, 32'hDEAD_BEEF);
      wr(APRESC, 32'd5);
      wr(ACTRL, 32'h6);
      drive(1'b1, 1'b1, ACTRL, SZW, 32'd0);
      HRESETn = 1'b0;
      drive(1'b0, 1'b0, 32'd0, SZW, 32'h7);
      drive(1'b0, 1'b0, 32'd0, SZW, 32'd0);
      HRESETn = 1'b1;
      checks++;
      if (TIMER_IRQ !== 1'b0 || HRDATA !== 32'd0) begin
         errors++;
         $display("FAIL reset_outputs irq=%b hrdata=%h expected irq=0 hrdata=0", TIMER_IRQ, HRDATA);
      end
      for (int i = 0; i < 8; i++) begin
         rd(32'(i * 4), d, at, irq);
         checks++;
         if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_read off=%0h got=%h expected=0", i * 4, d);
         end
         checks++;
         if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp hreadyout=%b hresp=%b expected 1/0", HREADYOUT, HRESP);
         end
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      int at;
      logic irq;
      wr(APRESC, 32'd0);
      wr(ALOAD, 32'd3);
      drive(1'b1, 1'b1, ACTRL, SZW, 32'd0);
      drive(1'b1, 1'b0, AVALUE, SZW, 32'h3);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (HRDATA !== 32'(3 - i)) begin
            errors++;
            $display("FAIL oneshot_value step=%0d got=%h expected=%h", i, HRDATA, 3 - i);
         end
         if (i < 3) drive(1'b1, 1'b0, AVALUE, SZW, 32'd0);
      end
      checks++;
      if (TIMER_IRQ !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_irq_early got=%b expected=0", TIMER_IRQ);
      end
      drive(1'b1, 1'b0, ACTRL, SZW, 32'd0);
      checks++;
      if (HRDATA !== 32'h2 || TIMER_IRQ !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_expire ctrl=%h irq=%b expected ctrl=2 irq=1", HRDATA, TIMER_IRQ);
      end
      drive(1'b0, 1'b0, 32'd0, SZW, 32'd0);
      wr(ASTATUS, 32'd0);
      checks++;
      if (TIMER_IRQ !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_w0_status irq=%b expected=1", TIMER_IRQ);
      end
      drive(1'b1, 1'b1, ASTATUS, SZW, 32'd0);
      checks++;
      if (TIMER_IRQ !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_irq_before_clear got=%b expected=1", TIMER_IRQ);
      end
      drive(1'b0, 1'b0, 32'd0, SZW, 32'd1);
      checks++;
      if (TIMER_IRQ !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_irq_clear got=%b expected=0", TIMER_IRQ);
      end
      rd(AVALUE, d, at, irq);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL oneshot_value_hold got=%h expected=0", d);
      end
   endtask

   task automatic test_autoreload();
      int e;
      int n;
      wr(ACTRL, 32'd0);
      wr(APRESC, 32'd4);
      wr(ALOAD, 32'd9);
      wr(ACTRL, 32'h7);
      e = cyc;
      for (int j = 1; j <= 3; j++) begin
         n = 0;
         while (TIMER_IRQ !== 1'b1 && n < 200) begin
            drive(1'b0, 1'b0, 32'd0, SZW, 32'd0);
            n++;
         end
         checks++;
         if (cyc - e != 50 * j) begin
            errors++;
            $display("FAIL autoreload_period irq#%0d at=%0d expected=%0d", j, cyc - e, 50 * j);
         end
         wr(ASTATUS, 32'd1);
         checks++;
         if (TIMER_IRQ !== 1'b0) begin
            errors++;
            $display("FAIL autoreload_clear irq=%b expected=0", TIMER_IRQ);
         end
      end
      wr(ACTRL, 32'd0);
   endtask

   task automatic test_simultaneous();
      logic [31:0] d;
      int at, e, ld;
      logic irq;
      wr(APRESC, 32'd0);
      wr(ALOAD, 32'd2);
      wr(ACTRL, 32'h3);
      drive(1'b0, 1'b0, 32'd0, SZW, 32'd0);
      drive(1'b1, 1'b1, ASTATUS, SZW, 32'd0);
      drive(1'b0, 1'b0, 32'd0, SZW, 32'd1);  // W1C commits on the expiry edge
      checks++;
      if (TIMER_IRQ !== 1'b1) begin
         errors++;
         $display("FAIL sim_set_vs_clear irq=%b expected=1", TIMER_IRQ);
      end
      rd(ASTATUS, d, at, irq);
      checks++;
      if (d !== 32'd1) begin
         errors++;
         $display("FAIL sim_status got=%h expected=1", d);
      end
      wr(ASTATUS, 32'd1);
      wr(ACTRL, 32'd0);
      wr(APRESC, 32'd3);
      wr(ALOAD, 32'd50);
      wr(ACTRL, 32'h1);
      e = cyc;
      repeat (6) drive(1'b0, 1'b0, 32'd0, SZW, 32'd0);
      drive(1'b1, 1'b1, ALOAD, SZW, 32'd0);
      drive(1'b0, 1'b0, 32'd0, SZW, 32'h100);
      ld = cyc;
      checks++;
      if (ld - e != 8) begin
         errors++;
         $display("FAIL sim_load_alignment edge=%0d expected=8", ld - e);
      end
      for (int i = 0; i < 3; i++) begin
         rd(AVALUE, d, at, irq);
         checks++;
         if (d !== 32'(256 - (at - ld) / 4)) begin
            errors++;
            $display("FAIL sim_load_vs_tick t=%0d got=%h expected=%h", at - ld, d,
                     256 - (at - ld) / 4);
         end
      end
      wr(ACTRL, 32'd0);
   endtask

   task automatic test_subword();
      logic [31:0] d;
      int at;
      logic irq;
      wr(ALOAD, 32'h77);
      drive(1'b1, 1'b1, ACTRL, 3'b000, 32'd0);
      checks++;
      if (HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
         errors++;
         $display("FAIL subword_resp hresp=%b hreadyout=%b expected 0/1", HRESP, HREADYOUT);
      end
      drive(1'b0, 1'b0, 32'd0, SZW, 32'hFF);
      rd(ACTRL, d, at, irq);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL subword_ctrl got=%h expected=0", d);
      end
      wr(32'h18, 32'hFFFF_FFFF);
      rd(32'h18, d, at, irq);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL unmapped_read got=%h expected=0", d);
      end
      wr(AVALUE, 32'h1234);
      rd(AVALUE, d, at, irq);
      checks++;
      if (d !== 32'h77) begin
         errors++;
         $display("FAIL value_ro got=%h expected=77", d);
      end
      wr_sz(ALOAD, 32'hAAAA, 3'b001);
      rd(ALOAD, d, at, irq);
      checks++;
      if (d !== 32'h77) begin
         errors++;
         $display("FAIL subword_load got=%h expected=77", d);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] d;
      int at;
      logic irq;
      drive(1'b1, 1'b1, ALOAD, SZW, 32'd0);
      drive(1'b1, 1'b0, AVALUE, SZW, 32'd5);
      checks++;
      if (HRDATA !== 32'd5) begin
         errors++;
         $display("FAIL b2b_load_value got=%h expected=5", HRDATA);
      end
      drive(1'b1, 1'b1, APRESC, SZW, 32'd0);
      drive(1'b1, 1'b0, APRESC, SZW, 32'd7);
      checks++;
      if (HRDATA !== 32'd7) begin
         errors++;
         $display("FAIL b2b_presc got=%h expected=7", HRDATA);
      end
      drive(1'b0, 1'b0, 32'd0, SZW, 32'd0);
      HREADY = 1'b0;
      repeat (3) drive(1'b1, 1'b1, ALOAD, SZW, 32'h99);
      checks++;
      if (HRDATA !== 32'd0) begin
         errors++;
         $display("FAIL stall_hrdata got=%h expected=0", HRDATA);
      end
      HREADY = 1'b1;
      drive(1'b0, 1'b0, 32'd0, SZW, 32'h99);
      rd(ALOAD, d, at, irq);
      checks++;
      if (d !== 32'd5) begin
         errors++;
         $display("FAIL stall_load got=%h expected=5", d);
      end
      rd(AVALUE, d, at, irq);
      checks++;
      if (d !== 32'd5) begin
         errors++;
         $display("FAIL stall_value got=%h expected=5", d);
      end
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic irq;
      int at, e, p, l, rl, k, n, expv, gap;
      logic exp_irq;
      for (int it = 0; it < 6; it++) begin
         p  = int'($urandom_range(0, 5));
         l  = int'($urandom_range(0, 12));
         rl = int'($urandom_range(0, 1));
         wr(ACTRL, 32'd0);
         wr(ASTATUS, 32'd1);
         wr(APRESC, 32'(p));
         wr(ALOAD, 32'(l));
         wr(ACTRL, 32'(3 + 4 * rl));
         e = cyc;
         for (int r = 0; r < 4; r++) begin
            gap = int'($urandom_range(0, 15));
            repeat (gap) drive(1'b0, 1'b0, 32'd0, SZW, 32'd0);
            rd(AVALUE, d, at, irq);
            k = at - e;
            n = k / (p + 1);
            if (rl != 0) expv = l - (n % (l + 1));
            else expv = (n >= l) ? 0 : l - n;
            exp_irq = (n >= l + 1);
            checks++;
            if (d !== 32'(expv) || irq !== exp_irq) begin
               errors++;
               $display("FAIL random p=%0d l=%0d rl=%0d t=%0d value=%h irq=%b expected %h/%b",
                        p, l, rl, k, d, irq, expv, exp_irq);
            end
         end
      end
      wr(ACTRL, 32'd0);
   endtask

   initial begin
      HRESETn = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      test_reset();
      test_oneshot();
      test_autoreload();
      test_simultaneous();
      test_subword();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/ahblite_timer.md
# ahblite_timer

Memory-mapped 32-bit down-counting timer with a programmable prescaler and interrupt output. It is an AHB-Lite slave that sits downstream of the system AHB-Lite interconnect and occupies one peripheral port (HSEL, address/control, HREADY in; HREADYOUT/HRDATA/HRESP out). It is a zero-wait-state, register-only slave. The interrupt line goes to the core's IRQ input.

## Interface
Parameters:
- PRESC_W, 16: width of the prescaler register and prescale counter.

Ports:
- HCLK, input, 1: the only clock; all state updates on its rising edge.
- HRESETn, input, 1: reset, synchronous and active-low.
- HSEL, input, 1: slave select from the interconnect decoder.
- HADDR, input, 32: address; only HADDR[4:2] is decoded.
- HTRANS, input, 2: transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is a valid transfer.
- HSIZE, input, 3: transfer size; only 3'b010 (word) writes take effect.
- HWRITE, input, 1: 1 = write.
- HWDATA, input, 32: write data, valid in the data phase.
- HREADY, input, 1: bus-wide ready from the interconnect.
- HREADYOUT, output, 1: constant 1.
- HRESP, output, 1: constant 0 (OKAY).
- HRDATA, output, 32: read data for the data phase.
- TIMER_IRQ, output, 1: level interrupt, equal to STATUS.IRQ AND CTRL.IRQEN.

## Operation
Register map (offset):
- 0x00 CTRL, RW: bit0 EN, bit1 IRQEN, bit2 RELOAD; bits 31:3 read 0.
- 0x04 LOAD, RW, 32 bits. A write also copies the data into VALUE and clears the prescale counter.
- 0x08 VALUE, RO: current count. Writes are ignored.
- 0x0C STATUS: bit0 IRQ. Writing 1 to bit0 clears it; writing 0 has no effect.
- 0x10 PRESC, RW: bits PRESC_W-1:0; upper bits read 0.
- 0x14–0x1C: reads return 0; writes are ignored.

Bus handling:
- Address phase is accepted when HSEL & HREADY & HTRANS[1].
- On acceptance, the slave registers the address index, the write flag and (HSIZE==3'b010) into data-phase registers.
- The data-phase valid flag clears on any non-accepted HREADY cycle.
- Writes commit at the clock edge that ends the data phase, using HWDATA.
- Sub-word writes complete on the bus with OKAY but change nothing.
- HRDATA is a combinational mux of the registers, selected by the registered address index. It is 0 when no read data phase is active.

Counting (only when CTRL.EN=1):
- The prescale counter increments each cycle. When it equals PRESC, it returns to 0 and generates one tick.
- On a tick with VALUE != 0: VALUE decrements by 1.
- On a tick with VALUE == 0: STATUS.IRQ is set. Then:
  - if RELOAD=1: VALUE <= LOAD;
  - otherwise: CTRL.EN <= 0 and VALUE stays 0.
- Tick period is PRESC+1 cycles. The auto-reload IRQ period is (LOAD+1)*(PRESC+1) cycles.
- When EN=0, the prescale counter holds its value and VALUE holds.

Simultaneous events:
- IRQ set and W1C clear in the same cycle: set wins.
- LOAD write and tick in the same cycle: the LOAD write wins (VALUE=new data, prescaler=0), and no decrement occurs.
- CTRL write and auto-disable in the same cycle: the written EN wins.
- Writing PRESC below the current prescale count: the counter continues to wrap at 2^PRESC_W. This is the accepted boundary behaviour.

## Timing
- Reset (HRESETn=0 at a rising edge):
  - CTRL, LOAD, VALUE, PRESC, STATUS, the prescale counter and the data-phase registers all go to 0.
  - TIMER_IRQ=0; HRDATA=0; HREADYOUT=1; HRESP=0.
  - An in-flight data phase is discarded.
- Write latency: a register updates at the edge ending the data phase. A read in the immediately following transfer returns the new value.
- Read latency: zero wait states; data is valid during the data phase.
- TIMER_IRQ rises in the cycle after the edge on which IRQ is set, given IRQEN=1. It falls in the cycle after the W1C data phase completes.
- VALUE changes only on tick edges or LOAD-write edges.

## Test plan
- **Reset:** hold HRESETn=0 for 2 cycles, then read all 8 offsets. Required: every read returns 0, and HREADYOUT=1 and HRESP=0 throughout.
- **One-shot:** write PRESC=0, LOAD=3, CTRL=0x3. Required: VALUE reads 3,2,1,0 on successive cycles. IRQ sets on the 4th tick after enable. TIMER_IRQ=1 and CTRL reads 0x2 (EN auto-cleared). Writing STATUS=1 drops TIMER_IRQ the next cycle.
- **Auto-reload with prescaler:** PRESC=4, LOAD=9, CTRL=0x7. Required: TIMER_IRQ asserts every 50 cycles. Clear the IRQ each time; it re-asserts after exactly 50 cycles.
- **Simultaneous events:** time a STATUS W1C to land on the same edge as an IRQ set. Required: IRQ stays 1. Time a LOAD=0x100 write to land on a tick edge. Required: VALUE reads 0x100.
- **Sub-word and unmapped accesses:** a byte write of 0xFF to CTRL leaves CTRL=0. A write to 0x18 followed by a read of 0x18 returns 0. A write to VALUE is ignored. All complete with HRESP=0.
- **Pipelining:** perform back-to-back writes LOAD=5 then read VALUE with no idle cycle, and assert HSEL with HREADY=0 stalls. Required: the read returns 5, and non-accepted cycles cause no writes.
